// File: rtl/alarm_bank_ctrl_pkg.sv
// alarm_bank_ctrl_pkg
//   Shared definitions for the alarm bank controller: FSM state encoding,
//   default sizing, and the field layout of a time word.
//   Optional feature macro used by the bank: ALARM_AUTO_OFF_EN.
package alarm_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam int DEF_N_CH         = 7;
  localparam int DEF_W            = 13;
  localparam int DEF_AW           = 3;
  localparam int DEF_SNOOZE_MIN   = 9;
  localparam int DEF_SW           = 4;
  localparam int DEF_RING_TIMEOUT = 5;

  // Time word layout: minutes in the low field, hours above them.
  // The remaining top bits are spare. The bank only does whole-word
  // equality, so this layout matters to the producers of cur_time.
  localparam int TF_MIN_LSB  = 0;
  localparam int TF_MIN_W    = 6;
  localparam int TF_HOUR_LSB = 6;
  localparam int TF_HOUR_W   = 5;

  function automatic logic [DEF_W-1:0] pack_time(input logic [TF_HOUR_W-1:0] hour,
                                                 input logic [TF_MIN_W-1:0]  minute);
    logic [DEF_W-1:0] t;
    t = '0;
    t[TF_HOUR_LSB +: TF_HOUR_W] = hour;
    t[TF_MIN_LSB  +: TF_MIN_W]  = minute;
    return t;
  endfunction

endpackage

// File: rtl/alarm_bank_ctrl_if.sv
// alarm_bank_ctrl_if
//   Bundles the alarm bank's write port, read port, time-keeping inputs,
//   user handshakes and status outputs. Signal prefixes are from the
//   bank's point of view (i_ = into the bank, o_ = out of the bank).
//   master: the surrounding logic (time-keeper, UI, buzzer/display).
//   slave : alarm_bank_ctrl.
//   ALARM_AUTO_OFF_EN adds the sticky o_missed status.
interface alarm_bank_ctrl_if
  import alarm_bank_ctrl_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW,
  parameter int SW = DEF_SW
);
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [W-1:0]  i_wr_data;
  logic          i_wr_arm;
  logic [AW-1:0] i_rd_addr;
  logic [W-1:0]  o_rd_data;
  logic          o_rd_armed;
  logic [AW-1:0] i_day;
  logic [W-1:0]  i_cur_time;
  logic          i_min_tick;
  logic          i_ack;
  logic          i_snooze;
  logic          o_ring;
  logic [1:0]    o_state;
  logic [SW-1:0] o_snooze_left;
`ifdef ALARM_AUTO_OFF_EN
  logic          o_missed;
`endif

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_wr_arm, i_rd_addr,
    output i_day, i_cur_time, i_min_tick, i_ack, i_snooze,
`ifdef ALARM_AUTO_OFF_EN
    input  o_missed,
`endif
    input  o_rd_data, o_rd_armed, o_ring, o_state, o_snooze_left
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_wr_arm, i_rd_addr,
    input  i_day, i_cur_time, i_min_tick, i_ack, i_snooze,
`ifdef ALARM_AUTO_OFF_EN
    output o_missed,
`endif
    output o_rd_data, o_rd_armed, o_ring, o_state, o_snooze_left
  );

endinterface

// File: rtl/alarm_bank_ctrl_entry_file.sv
// alarm_entry_file
//   N_CH x (W+1) alarm register file: synchronous write, registered read
//   port (read-before-write), and a combinational view of entry[day] for
//   the match engine. Out-of-range addresses write nothing and read 0.
//   Ports: i_clk, i_clr (sync active-high), write port i_wr_*, read port
//   i_rd_addr/o_rd_data/o_rd_armed, day view i_day/o_day_*.
module alarm_entry_file
  import alarm_bank_ctrl_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W,
  parameter int AW   = DEF_AW
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_wr_arm,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data,
  output logic          o_rd_armed,
  input  logic [AW-1:0] i_day,
  output logic [W-1:0]  o_day_data,
  output logic          o_day_armed,
  output logic          o_day_valid
);

  localparam logic [AW:0] LP_N_CH = N_CH[AW:0];

  logic [W-1:0]    r_entry [N_CH];
  logic [N_CH-1:0] r_armed;
  logic [W-1:0]    r_rd_data;
  logic            r_rd_armed;

  logic w_wr_ok;
  logic w_rd_ok;

  assign w_wr_ok     = i_wr_en & ({1'b0, i_wr_addr} < LP_N_CH);
  assign w_rd_ok     = ({1'b0, i_rd_addr} < LP_N_CH);
  assign o_day_valid = ({1'b0, i_day} < LP_N_CH);

  // Gated so an out-of-range day never presents a phantom entry.
  assign o_day_data  = o_day_valid ? r_entry[i_day] : '0;
  assign o_day_armed = o_day_valid & r_armed[i_day];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < N_CH; i++) r_entry[i] <= '0;
      r_armed    <= '0;
      r_rd_data  <= '0;
      r_rd_armed <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_entry[i_wr_addr] <= i_wr_data;
        r_armed[i_wr_addr] <= i_wr_arm;
      end
      if (w_rd_ok) begin
        r_rd_data  <= r_entry[i_rd_addr];
        r_rd_armed <= r_armed[i_rd_addr];
      end else begin
        r_rd_data  <= '0;
        r_rd_armed <= 1'b0;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_armed = r_rd_armed;

endmodule

// File: rtl/alarm_bank_ctrl.sv
// alarm_bank_ctrl
//   Per-day alarm bank with match engine and ringing/snooze FSM.
//   Ports: i_clk, i_clr (sync active-high, highest priority),
//   io (alarm_bank_ctrl_if.slave): entry write/read ports, day/cur_time/
//   min_tick from the time-keeper, ack/snooze handshakes, registered
//   ring/state/snooze_left outputs.
//   ALARM_AUTO_OFF_EN: RINGING times out after RING_TIMEOUT minute ticks
//   and sets the sticky o_missed flag, cleared by the next entry write.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | waiting for a minute tick matching the armed day entry
//   ST_RINGING | buzzer on; ack stops, snooze defers
//   ST_SNOOZE  | buzzer off; counts snooze_left down on minute ticks
module alarm_bank_ctrl
  import alarm_bank_ctrl_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int W            = DEF_W,
  parameter int AW           = DEF_AW,
  parameter int SNOOZE_MIN   = DEF_SNOOZE_MIN,
  parameter int SW           = DEF_SW,
  parameter int RING_TIMEOUT = DEF_RING_TIMEOUT
) (
  input logic               i_clk,
  input logic               i_clr,
  alarm_bank_ctrl_if.slave  io
);

  localparam logic [AW:0]   LP_N_CH   = N_CH[AW:0];
  localparam logic [SW-1:0] LP_SNOOZE = SNOOZE_MIN[SW-1:0];

  state_e        r_state, w_state_nxt;
  logic          r_ring;
  logic [SW-1:0] r_snooze_left, w_snooze_nxt;

  logic [W-1:0]  w_day_data;
  logic          w_day_armed;
  logic          w_day_valid;
  logic          w_wr_valid;
  logic          w_match;
  logic          w_disarm;

  alarm_entry_file #(
    .N_CH (N_CH),
    .W    (W),
    .AW   (AW)
  ) u_entry_file (
    .i_clk       (i_clk),
    .i_clr       (i_clr),
    .i_wr_en     (io.i_wr_en),
    .i_wr_addr   (io.i_wr_addr),
    .i_wr_data   (io.i_wr_data),
    .i_wr_arm    (io.i_wr_arm),
    .i_rd_addr   (io.i_rd_addr),
    .o_rd_data   (io.o_rd_data),
    .o_rd_armed  (io.o_rd_armed),
    .i_day       (io.i_day),
    .o_day_data  (w_day_data),
    .o_day_armed (w_day_armed),
    .o_day_valid (w_day_valid)
  );

  assign w_wr_valid = io.i_wr_en & ({1'b0, io.i_wr_addr} < LP_N_CH);

  // Entry file outputs are register contents, so this sees pre-write data.
  assign w_match = io.i_min_tick & w_day_valid & w_day_armed &
                   (w_day_data == io.i_cur_time);

  assign w_disarm = w_wr_valid & ~io.i_wr_arm & (io.i_wr_addr == io.i_day) &
                    (r_state != ST_IDLE);

`ifdef ALARM_AUTO_OFF_EN
  localparam int           TW     = $clog2(RING_TIMEOUT + 1);
  localparam logic [TW-1:0] LP_TMO = RING_TIMEOUT[TW-1:0];

  // Down-counter: loaded on entry to RINGING, terminal count at 1 tick left.
  logic [TW-1:0] r_tmo_cnt, w_tmo_nxt;
  logic          r_missed, w_missed_nxt;
  logic          w_timeout;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_snooze_nxt = r_snooze_left;
`ifdef ALARM_AUTO_OFF_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_match) w_state_nxt = ST_RINGING;
      end
      ST_RINGING: begin
        if (io.i_ack) begin
          w_state_nxt = ST_IDLE;
        end else if (io.i_snooze) begin
          w_state_nxt  = ST_SNOOZE;
          w_snooze_nxt = LP_SNOOZE;
        end
`ifdef ALARM_AUTO_OFF_EN
        else if (io.i_min_tick && (r_tmo_cnt == TW'(1))) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end
`endif
      end
      ST_SNOOZE: begin
        if (io.i_ack) begin
          w_state_nxt  = ST_IDLE;
          w_snooze_nxt = '0;
        end else if (io.i_min_tick) begin
          if (r_snooze_left == SW'(1)) begin
            w_state_nxt  = ST_RINGING;
            w_snooze_nxt = '0;
          end else begin
            w_snooze_nxt = r_snooze_left - SW'(1);
          end
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_snooze_nxt = '0;
      end
    endcase
    if (w_disarm) begin
      w_state_nxt  = ST_IDLE;
      w_snooze_nxt = '0;
`ifdef ALARM_AUTO_OFF_EN
      w_timeout    = 1'b0;
`endif
    end
  end

`ifdef ALARM_AUTO_OFF_EN
  always_comb begin
    w_tmo_nxt    = r_tmo_cnt;
    w_missed_nxt = r_missed;
    if ((w_state_nxt == ST_RINGING) && (r_state != ST_RINGING)) begin
      w_tmo_nxt = LP_TMO;
    end else if ((r_state == ST_RINGING) && io.i_min_tick && (r_tmo_cnt != '0)) begin
      w_tmo_nxt = r_tmo_cnt - TW'(1);
    end
    // A timeout in the same cycle as a write still leaves missed set.
    if (w_timeout) begin
      w_missed_nxt = 1'b1;
    end else if (w_wr_valid) begin
      w_missed_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_tmo_cnt <= '0;
      r_missed  <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_nxt;
      r_missed  <= w_missed_nxt;
    end
  end

  assign io.o_missed = r_missed;
`endif

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state       <= ST_IDLE;
      r_ring        <= 1'b0;
      r_snooze_left <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ring        <= (w_state_nxt == ST_RINGING);
      r_snooze_left <= w_snooze_nxt;
    end
  end

  assign io.o_ring        = r_ring;
  assign io.o_state       = r_state;
  assign io.o_snooze_left = r_snooze_left;

endmodule

// File: tb/tb_alarm_bank_ctrl.sv
module tb_alarm_bank_ctrl;
  import alarm_bank_ctrl_pkg::*;

  logic clk;
  logic clr;
  int   n_run;
  int   n_fail;

  alarm_bank_ctrl_if #(.W(13), .AW(3), .SW(4)) bus ();

  alarm_bank_ctrl #(
    .N_CH(7), .W(13), .AW(3), .SNOOZE_MIN(9), .SW(4), .RING_TIMEOUT(5)
  ) dut (
    .i_clk (clk),
    .i_clr (clr),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [12:0] d, input logic arm);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = a;
    bus.i_wr_data = d;
    bus.i_wr_arm  = arm;
    step();
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic tick();
    bus.i_min_tick = 1'b1;
    step();
    bus.i_min_tick = 1'b0;
    step();
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    clr = 1'b1;
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_wr_arm = 1'b0;
    bus.i_rd_addr = '0; bus.i_day = '0; bus.i_cur_time = '0;
    bus.i_min_tick = 1'b0; bus.i_ack = 1'b0; bus.i_snooze = 1'b0;
    step(); step();
    clr = 1'b0;
    chk("rst_state", bus.o_state, 0);
    chk("rst_ring", bus.o_ring, 0);
    chk("rst_snz", bus.o_snooze_left, 0);
    chk("rst_rd", bus.o_rd_data, 0);

    // write / read
    wr(3'd2, 13'h0A5, 1'b1);
    bus.i_rd_addr = 3'd2;
    step();
    chk("rd2_data", bus.o_rd_data, 13'h0A5);
    chk("rd2_arm", bus.o_rd_armed, 1);
    bus.i_rd_addr = 3'd7;
    step();
    chk("rd7_data", bus.o_rd_data, 0);
    chk("rd7_arm", bus.o_rd_armed, 0);
    // read-before-write on same address
    bus.i_rd_addr = 3'd2;
    wr(3'd2, 13'h111, 1'b1);
    chk("rbw_old", bus.o_rd_data, 13'h0A5);
    step();
    chk("rbw_new", bus.o_rd_data, 13'h111);
    // out-of-range write ignored, entry 2 untouched
    wr(3'd7, 13'h1FF, 1'b1);
    chk("oor_wr", bus.o_rd_data, 13'h111);
    wr(3'd2, 13'h0A5, 1'b1);

    // match -> ringing, ack -> idle
    bus.i_day = 3'd2;
    bus.i_cur_time = 13'h0A5;
    tick();
    chk("match_state", bus.o_state, 1);
    chk("match_ring", bus.o_ring, 1);
    bus.i_ack = 1'b1; step(); bus.i_ack = 1'b0;
    chk("ack_state", bus.o_state, 0);
    chk("ack_ring", bus.o_ring, 0);

    // snooze cycle
    tick();
    chk("ring2", bus.o_state, 1);
    bus.i_snooze = 1'b1; step(); bus.i_snooze = 1'b0;
    chk("snz_state", bus.o_state, 2);
    chk("snz_left", bus.o_snooze_left, 9);
    chk("snz_ring", bus.o_ring, 0);
    tick();
    chk("snz_left8", bus.o_snooze_left, 8);
    for (int i = 0; i < 7; i++) tick();
    chk("snz_left1", bus.o_snooze_left, 1);
    chk("snz_still", bus.o_state, 2);
    tick();
    chk("resnz_state", bus.o_state, 1);
    chk("resnz_ring", bus.o_ring, 1);
    chk("resnz_left", bus.o_snooze_left, 0);
    bus.i_ack = 1'b1; bus.i_snooze = 1'b1; step();
    bus.i_ack = 1'b0; bus.i_snooze = 1'b0;
    chk("acksnz_state", bus.o_state, 0);
    chk("acksnz_left", bus.o_snooze_left, 0);

    // snooze then ack from SNOOZE
    tick();
    bus.i_snooze = 1'b1; step(); bus.i_snooze = 1'b0;
    tick();
    bus.i_ack = 1'b1; step(); bus.i_ack = 1'b0;
    chk("snzack_state", bus.o_state, 0);
    chk("snzack_left", bus.o_snooze_left, 0);

    // no-trigger cases
    wr(3'd2, 13'h0A5, 1'b0);
    tick();
    chk("unarmed", bus.o_state, 0);
    wr(3'd2, 13'h0A5, 1'b1);
    bus.i_day = 3'd7;
    tick();
    chk("day7", bus.o_state, 0);
    bus.i_day = 3'd2;
    bus.i_cur_time = 13'h0A4;
    tick();
    chk("mismatch", bus.o_state, 0);
    bus.i_cur_time = 13'h0A5;

    // write in the match cycle: old contents decide
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 3'd2; bus.i_wr_data = 13'h0A6; bus.i_wr_arm = 1'b1;
    bus.i_min_tick = 1'b1;
    step();
    bus.i_wr_en = 1'b0; bus.i_min_tick = 1'b0;
    chk("wrmatch_old", bus.o_state, 1);
    bus.i_ack = 1'b1; step(); bus.i_ack = 1'b0;
    bus.i_wr_en = 1'b1; bus.i_wr_data = 13'h0A5;
    bus.i_min_tick = 1'b1;
    step();
    bus.i_wr_en = 1'b0; bus.i_min_tick = 1'b0;
    chk("wrmatch_new", bus.o_state, 0);

    // disarm while ringing / snoozing; unrelated write keeps ringing
    tick();
    chk("dis_pre", bus.o_state, 1);
    wr(3'd4, 13'h000, 1'b0);
    chk("other_wr", bus.o_state, 1);
    wr(3'd2, 13'h0A5, 1'b0);
    chk("dis_ring", bus.o_state, 0);
    chk("dis_ringo", bus.o_ring, 0);
    wr(3'd2, 13'h0A5, 1'b1);
    tick();
    bus.i_snooze = 1'b1; step(); bus.i_snooze = 1'b0;
    wr(3'd2, 13'h0A5, 1'b0);
    chk("dis_snz", bus.o_state, 0);
    chk("dis_snzl", bus.o_snooze_left, 0);
    wr(3'd2, 13'h0A5, 1'b1);

    // day change while ringing, then CLR
    tick();
    bus.i_day = 3'd3;
    step();
    chk("daychg", bus.o_state, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_state", bus.o_state, 0);
    chk("clr_ring", bus.o_ring, 0);
    bus.i_rd_addr = 3'd2;
    step();
    chk("clr_rd", bus.o_rd_data, 0);
    chk("clr_arm", bus.o_rd_armed, 0);

`ifdef ALARM_AUTO_OFF_EN
    bus.i_day = 3'd2;
    wr(3'd2, 13'h0A5, 1'b1);
    chk("ao_miss0", bus.o_missed, 0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("ao_4ticks", bus.o_state, 1);
    tick();
    chk("ao_state", bus.o_state, 0);
    chk("ao_missed", bus.o_missed, 1);
    wr(3'd5, 13'h001, 1'b0);
    chk("ao_clear", bus.o_missed, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_bank_ctrl.md
Name: alarm_bank_ctrl

Overview:
- Parametrised successor of the per-day alarm register bank: N_CH alarm entries, each W bits plus an armed bit, written through an addressed port.
- Adds a match engine that compares the active day's entry against current time on every minute tick, and a ringing/snooze state machine with ack/snooze handshakes.
- Sits between the time-keeping counter (cur_time, day, min_tick) and the buzzer/display logic.

Parameters:
- N_CH, 7, number of alarm entries (one per day).
- W, 13, alarm/time word width.
- AW, 3, address width; must satisfy 2**AW >= N_CH.
- SNOOZE_MIN, 9, minute ticks spent in SNOOZE before re-ringing; must be >= 1.
- SW, 4, snooze counter width; must satisfy 2**SW > SNOOZE_MIN.
- RING_TIMEOUT, 5, minute ticks before auto-off; used only with ALARM_AUTO_OFF_EN.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- CLR  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  entry to write.
- wr_data  in  W  alarm time.
- wr_arm  in  1  armed bit written with the entry.
- rd_addr  in  AW  read address.
- rd_data  out  W  registered read data.
- rd_armed  out  1  registered armed bit of rd_addr.
- day  in  AW  active entry index.
- cur_time  in  W  current time, already updated in the min_tick cycle.
- min_tick  in  1  one-cycle pulse per minute.
- ack  in  1  stop alarm.
- snooze  in  1  snooze request.
- ring  out  1  buzzer drive; high in RINGING.
- state  out  2  IDLE=0, RINGING=1, SNOOZE=2.
- snooze_left  out  SW  remaining snooze ticks.

Behaviour:
- CLR high at an edge: all entries, armed bits, rd_data and rd_armed go to 0; state goes to IDLE; ring=0; snooze_left=0. CLR has priority over every other input and aborts ringing/snooze immediately.
- Write: when wr_en=1 and wr_addr<N_CH, the entry and its armed bit update at the edge. wr_addr>=N_CH is ignored.
- Read: latency 1. rd_data/rd_armed reflect the contents before the edge (read-before-write on the same address). rd_addr>=N_CH returns 0/0.
- Match: match = min_tick & (day<N_CH) & armed[day] & (entry[day]==cur_time), evaluated on pre-write contents. Exact W-bit equality; no wrap arithmetic.
- IDLE:
  - match -> RINGING next edge.
- RINGING (ring=1):
  - ack -> IDLE.
  - else snooze -> SNOOZE, snooze_left<=SNOOZE_MIN.
  - ack and snooze in the same cycle: ack wins.
  - Matches ignored.
- SNOOZE:
  - ack -> IDLE, snooze_left<=0.
  - min_tick with snooze_left==1 -> RINGING, snooze_left<=0.
  - Otherwise min_tick decrements snooze_left.
  - snooze input ignored; matches ignored.
- Disarm: a write with wr_arm=0 to wr_addr==day while in RINGING or SNOOZE forces IDLE at the next edge (priority just below CLR).
- Changing day while RINGING/SNOOZE does not affect state.
- ring and state are registered outputs; no combinational path from inputs.

Optional Feature:
- ALARM_AUTO_OFF_EN defined:
  - A tick counter clears on entry to RINGING and counts min_tick while RINGING.
  - When it reaches RING_TIMEOUT, the FSM goes to IDLE and the sticky output missed (1 bit, reset 0) sets.
  - missed clears on the next write to any entry.
- ALARM_AUTO_OFF_EN undefined: RINGING persists until ack, snooze, disarm or CLR; the missed port is absent.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RINGING, ST_SNOOZE), default W/N_CH, time-word field layout constants.
- One sub-module, alarm_entry_file: N_CH x (W+1) register file with synchronous write, registered read and a combinational read of entry[day] for the match.
- FSM and counters stay in the top level.

Test Plan:
- CLR, then write entry 2 = 13'h0A5 armed; rd_addr=2 -> rd_data=13'h0A5 and rd_armed=1 one cycle later; rd_addr=7 -> 0.
- day=2, cur_time=13'h0A5, min_tick pulse -> state=RINGING, ring=1 on the next edge; ack -> IDLE, ring=0.
- Ringing, snooze pulse -> SNOOZE with snooze_left=9; 9 min_ticks -> RINGING after the 9th; assert ack+snooze together -> IDLE.
- Matching entry with armed=0, or day=7 -> no transition. Write to the same entry in the match cycle -> old value is used.
- Ringing, write wr_addr=day with wr_arm=0 -> IDLE. Ringing, assert CLR -> IDLE, ring=0, all entries 0.
- With ALARM_AUTO_OFF_EN: 5 min_ticks while RINGING -> IDLE and missed=1; the next write clears missed.
